// File: rtl/ssr_spi_reader.sv
// ssr_spi_reader: SPI mode-0 master that fetches SSR bytes for the distribution unit.
// Define SSR_CMD_BYTE_EN to shift CMD_OPCODE out on MOSI once at the start of each frame.
module ssr_spi_reader #(
    parameter int unsigned CLK_DIV    = 4,
    parameter logic [7:0]  CMD_OPCODE = 8'h03
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       readssr_req,
    output logic       byte_ready,
    output logic [7:0] byte_in,
    input  logic       byte_received_ack,
    output logic       spi_cs_n,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       busy
);

    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

`ifdef SSR_CMD_BYTE_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_CMD,
        S_SHIFT,
        S_PRESENT,
        S_WAIT_ACK_HI,
        S_WAIT_ACK_LO
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_SHIFT,
        S_PRESENT,
        S_WAIT_ACK_HI,
        S_WAIT_ACK_LO
    } state_t;
`endif

    state_t        state_q, state_nx;
    logic [DW-1:0] div_q, div_nx;
    logic [2:0]    bit_q, bit_nx;
    logic [7:0]    sh_q, sh_nx;
    logic          sclk_q, sclk_nx;
    logic          cs_n_q, cs_n_nx;
    logic          rdy_q, rdy_nx;
    logic [7:0]    byte_q, byte_nx;
    logic          tick;

`ifdef SSR_CMD_BYTE_EN
    logic [7:0]    tx_q, tx_nx;
    logic          mosi_q, mosi_nx;
`endif

    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= 3'd7;
            sh_q    <= 8'h00;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            rdy_q   <= 1'b0;
            byte_q  <= 8'h00;
`ifdef SSR_CMD_BYTE_EN
            tx_q    <= 8'h00;
            mosi_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_nx;
            div_q   <= div_nx;
            bit_q   <= bit_nx;
            sh_q    <= sh_nx;
            sclk_q  <= sclk_nx;
            cs_n_q  <= cs_n_nx;
            rdy_q   <= rdy_nx;
            byte_q  <= byte_nx;
`ifdef SSR_CMD_BYTE_EN
            tx_q    <= tx_nx;
            mosi_q  <= mosi_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state_q;
        div_nx   = div_q;
        bit_nx   = bit_q;
        sh_nx    = sh_q;
        sclk_nx  = sclk_q;
        rdy_nx   = rdy_q;
        byte_nx  = byte_q;
`ifdef SSR_CMD_BYTE_EN
        tx_nx    = tx_q;
        mosi_nx  = mosi_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (readssr_req) begin
                    state_nx = S_CS_SETUP;
                    div_nx   = '0;
                end
            end
            S_CS_SETUP: begin
                if (!readssr_req) begin
                    state_nx = S_IDLE;
                    div_nx   = '0;
                end else if (!tick) begin
                    div_nx = div_q + 1'b1;
                end else begin
                    div_nx = '0;
                    bit_nx = 3'd7;
`ifdef SSR_CMD_BYTE_EN
                    state_nx = S_CMD;
                    mosi_nx  = CMD_OPCODE[7];
                    tx_nx    = {CMD_OPCODE[6:0], 1'b0};
`else
                    state_nx = S_SHIFT;
`endif
                end
            end
`ifdef SSR_CMD_BYTE_EN
            S_CMD: begin
                if (!readssr_req) begin
                    state_nx = S_IDLE;
                    div_nx   = '0;
                    sclk_nx  = 1'b0;
                    mosi_nx  = 1'b0;
                end else if (!tick) begin
                    div_nx = div_q + 1'b1;
                end else begin
                    div_nx  = '0;
                    sclk_nx = ~sclk_q;
                    // MOSI moves only on the SCLK falling edge
                    if (sclk_q) begin
                        if (bit_q == 3'd0) begin
                            state_nx = S_SHIFT;
                            bit_nx   = 3'd7;
                            mosi_nx  = 1'b0;
                        end else begin
                            bit_nx  = bit_q - 1'b1;
                            mosi_nx = tx_q[7];
                            tx_nx   = {tx_q[6:0], 1'b0};
                        end
                    end
                end
            end
`endif
            S_SHIFT: begin
                if (!readssr_req) begin
                    state_nx = S_IDLE;
                    div_nx   = '0;
                    sclk_nx  = 1'b0;
                end else if (!tick) begin
                    div_nx = div_q + 1'b1;
                end else begin
                    div_nx  = '0;
                    sclk_nx = ~sclk_q;
                    if (!sclk_q) begin
                        sh_nx = {sh_q[6:0], spi_miso};
                    end else if (bit_q == 3'd0) begin
                        state_nx = S_PRESENT;
                    end else begin
                        bit_nx = bit_q - 1'b1;
                    end
                end
            end
            S_PRESENT: begin
                byte_nx  = sh_q;
                rdy_nx   = 1'b1;
                state_nx = S_WAIT_ACK_HI;
            end
            S_WAIT_ACK_HI: begin
                if (byte_received_ack) begin
                    rdy_nx   = 1'b0;
                    state_nx = S_WAIT_ACK_LO;
                end
            end
            S_WAIT_ACK_LO: begin
                if (!byte_received_ack) begin
                    if (readssr_req) begin
                        state_nx = S_SHIFT;
                        div_nx   = '0;
                        bit_nx   = 3'd7;
                        sclk_nx  = 1'b0;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
                sclk_nx  = 1'b0;
                rdy_nx   = 1'b0;
            end
        endcase
        cs_n_nx = (state_nx == S_IDLE);
    end

    assign byte_ready = rdy_q;
    assign byte_in    = byte_q;
    assign spi_cs_n   = cs_n_q;
    assign spi_sclk   = sclk_q;
    assign busy       = (state_q != S_IDLE);

`ifdef SSR_CMD_BYTE_EN
    assign spi_mosi = mosi_q;
`else
    // without the command phase the opcode never reaches the wire
    assign spi_mosi = |(CMD_OPCODE & 8'h00);
`endif

endmodule
